// File: rtl/led_event_logger_if.sv
// Record stream from the LED event logger: first-word fall-through head record,
// valid/ready handshake and FIFO occupancy.
interface led_event_logger_if #(
    parameter int N_LEDS     = 4,
    parameter int NB_TIME    = 14,
    parameter int LOG2_DEPTH = 3
);
    localparam int NB_REC = 2 + NB_TIME + 3 * N_LEDS;

    logic [NB_REC-1:0]   data;
    logic                valid;
    logic                ready;
    logic [LOG2_DEPTH:0] count;

    modport master (output data, output valid, output count, input ready);
    modport slave  (input data, input valid, input count, output ready);
endinterface

// File: rtl/led_event_logger.sv
// Watches three LED banks and logs baseline, change and timestamp-wrap records
// into a small first-word fall-through FIFO with sticky overflow accounting.
module led_event_logger #(
    parameter int N_LEDS     = 4,
    parameter int NB_TIME    = 14,
    parameter int LOG2_DEPTH = 3,
    parameter int NB_REC     = 2 + NB_TIME + 3 * N_LEDS
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [N_LEDS-1:0]     i_led,
    input  logic [N_LEDS-1:0]     i_led_b,
    input  logic [N_LEDS-1:0]     i_led_g,
    input  logic                  i_clear,
    led_event_logger_if.master    rec,
    output logic                  o_overflow,
    output logic [7:0]            o_drop_count
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ARM  = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] T_BASE = 2'b00;
    localparam logic [1:0] T_CHG  = 2'b01;
    localparam logic [1:0] T_WRAP = 2'b10;
    localparam logic [1:0] T_CW   = 2'b11;
    localparam logic [LOG2_DEPTH:0]   FULL_C  = {1'b1, {LOG2_DEPTH{1'b0}}};
    localparam logic [LOG2_DEPTH:0]   CNT_ONE = {{LOG2_DEPTH{1'b0}}, 1'b1};
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE = {{(LOG2_DEPTH-1){1'b0}}, 1'b1};
    localparam logic [NB_TIME-1:0]    TS_ONE  = {{(NB_TIME-1){1'b0}}, 1'b1};

    logic [1:0]              state_r, state_s;
    logic [NB_TIME-1:0]      ts_r;
    logic [3*N_LEDS-1:0]     snap_r, leds_s;
    logic [NB_REC-1:0]       mem_r [DEPTH];
    logic [LOG2_DEPTH-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LOG2_DEPTH:0]     count_r;
    logic                    push_s, pop_s, push_ok_s, drop_s, change_s, wrap_s, full_s;
    logic [NB_REC-1:0]       rec_s;

    function automatic logic [NB_REC-1:0] make_rec(input logic [1:0] kind,
                                                   input logic [NB_TIME-1:0] stamp,
                                                   input logic [3*N_LEDS-1:0] leds);
        return {kind, stamp, leds};
    endfunction

    assign leds_s   = {i_led_g, i_led_b, i_led};
    assign change_s = (leds_s != snap_r);
    assign wrap_s   = (ts_r == {NB_TIME{1'b1}});

    // Next state and the record (if any) generated at the coming edge
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        rec_s   = {NB_REC{1'b0}};
        case (state_r)
            IDLE: begin
                if (i_enable) state_s = ARM;
                else          state_s = IDLE;
            end
            ARM: begin
                push_s = 1'b1;
                rec_s  = make_rec(T_BASE, {NB_TIME{1'b0}}, leds_s);
                if (i_enable) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (i_enable) begin
                    push_s = change_s | wrap_s;
                    if (change_s && wrap_s) rec_s = make_rec(T_CW, ts_r, leds_s);
                    else if (change_s)      rec_s = make_rec(T_CHG, ts_r, leds_s);
                    else                    rec_s = make_rec(T_WRAP, ts_r, snap_r);
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves on the same edge
    assign full_s    = (count_r == FULL_C);
    assign pop_s     = (count_r != {(LOG2_DEPTH+1){1'b0}}) & rec.ready;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & full_s & ~pop_s;

    // Capture FSM, timestamp and input snapshot
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= IDLE;
            ts_r    <= {NB_TIME{1'b0}};
            snap_r  <= {(3*N_LEDS){1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == ARM) begin
                ts_r   <= {NB_TIME{1'b0}};
                snap_r <= leds_s;
            end else if (state_r == RUN && i_enable) begin
                ts_r <= ts_r + TS_ONE;
                if (change_s) snap_r <= leds_s;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_r <= {LOG2_DEPTH{1'b0}};
            rd_ptr_r <= {LOG2_DEPTH{1'b0}};
            count_r  <= {(LOG2_DEPTH+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are only observable while count is non-zero
    always_ff @(posedge clock) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= rec_s;
    end

    // Overflow status; a drop on the same edge as a clear or re-arm wins
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_overflow   <= 1'b0;
            o_drop_count <= 8'd0;
        end else if (drop_s) begin
            o_overflow <= 1'b1;
            if (i_clear || state_r == ARM)  o_drop_count <= 8'd1;
            else if (o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
            else                            o_drop_count <= o_drop_count;
        end else if (i_clear || state_r == ARM) begin
            o_overflow   <= 1'b0;
            o_drop_count <= 8'd0;
        end
    end

    // Head record, forced to zero while empty
    always_comb begin
        if (count_r != {(LOG2_DEPTH+1){1'b0}}) rec.data = mem_r[rd_ptr_r];
        else                                   rec.data = {NB_REC{1'b0}};
    end

    assign rec.valid = (count_r != {(LOG2_DEPTH+1){1'b0}});
    assign rec.count = count_r;
endmodule

// File: tb/tb_led_event_logger.sv
// Scoreboard bench for led_event_logger (NB_TIME=4 so wraps occur every 16 cycles).
module tb_led_event_logger;
    localparam int NL = 4;
    localparam int NT = 4;
    localparam int LD = 3;
    localparam int NR = 2 + NT + 3 * NL;

    logic            clock = 1'b0;
    logic            i_reset = 1'b0;
    logic            i_enable = 1'b0;
    logic            i_clear = 1'b0;
    logic [NL-1:0]   i_led = '0, i_led_b = '0, i_led_g = '0;
    logic            rdy = 1'b0;
    logic            o_overflow;
    logic [7:0]      o_drop_count;

    int n_vec = 0;
    int n_err = 0;

    logic [NR-1:0] q[$];
    logic [1:0]    st_m = 2'd0;
    logic [3:0]    ts_m = 4'd0;
    logic [11:0]   snap_m = 12'd0;
    logic          ovf_m = 1'b0;
    logic [7:0]    drops_m = 8'd0;

    always #5 clock = ~clock;

    led_event_logger_if #(.N_LEDS(NL), .NB_TIME(NT), .LOG2_DEPTH(LD)) rec ();
    assign rec.ready = rdy;

    led_event_logger #(.N_LEDS(NL), .NB_TIME(NT), .LOG2_DEPTH(LD)) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_led(i_led), .i_led_b(i_led_b), .i_led_g(i_led_g),
        .i_clear(i_clear), .rec(rec),
        .o_overflow(o_overflow), .o_drop_count(o_drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pat(input int k);
        logic [3:0] v;
        v = 4'(k);
        return {~v, v ^ 4'h5, v};
    endfunction

    // Monitor: status against the scoreboard, head record on every accepted pop
    always @(negedge clock) begin
        logic [NR-1:0] exp_rec;
        chk("count", 32'(rec.count), 32'(q.size()));
        chk("valid", 32'(rec.valid), 32'(q.size() != 0));
        chk("overflow", 32'(o_overflow), 32'(ovf_m));
        chk("drop_count", 32'(o_drop_count), 32'(drops_m));
        if (rec.valid && rdy && q.size() != 0) begin
            exp_rec = q.pop_front();
            chk("record", 32'(rec.data), 32'(exp_rec));
        end
    end

    // Expected behaviour at the coming edge, evaluated after the monitor's pop
    task automatic model_edge();
        logic [11:0]   in;
        logic [NR-1:0] r;
        logic          push, drop, chg, wr;
        logic [1:0]    nxt;
        in = {i_led_g, i_led_b, i_led};
        push = 1'b0; drop = 1'b0; r = '0; nxt = st_m;
        if (i_reset) begin
            case (st_m)
                2'd0: nxt = i_enable ? 2'd1 : 2'd0;
                2'd1: begin
                    push = 1'b1; r = {2'b00, 4'd0, in};
                    snap_m = in; ts_m = 4'd0; ovf_m = 1'b0; drops_m = 8'd0;
                    nxt = i_enable ? 2'd2 : 2'd0;
                end
                default: begin
                    if (i_enable) begin
                        chg = (in != snap_m);
                        wr  = (ts_m == 4'hF);
                        if (chg || wr) begin
                            push = 1'b1;
                            r = {wr, chg, ts_m, chg ? in : snap_m};
                        end
                        if (chg) snap_m = in;
                        ts_m = ts_m + 4'd1;
                    end else begin
                        nxt = 2'd0;
                    end
                end
            endcase
            if (push) begin
                if (q.size() < 8) q.push_back(r);
                else drop = 1'b1;
            end
            if (drop) begin
                ovf_m = 1'b1;
                drops_m = i_clear ? 8'd1 : ((drops_m == 8'hFF) ? 8'hFF : drops_m + 8'd1);
            end else if (i_clear) begin
                ovf_m = 1'b0; drops_m = 8'd0;
            end
            st_m = nxt;
        end
    endtask

    task automatic tick(input logic [11:0] v, input logic en, input logic r, input logic clr);
        {i_led_g, i_led_b, i_led} = v;
        i_enable = en; rdy = r; i_clear = clr;
        @(negedge clock); #1;
        model_edge();
        @(posedge clock); #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(rec.valid), 32'd0);
        chk("rst_count", 32'(rec.count), 32'd0);
        chk("rst_data", 32'(rec.data), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_drops", 32'(o_drop_count), 32'd0);

        // Baseline after release, then a change at timestamp 5
        i_reset = 1'b1;
        tick(12'h001, 1'b1, 1'b1, 1'b0);
        tick(12'h001, 1'b1, 1'b1, 1'b0);
        chk("baseline_valid", 32'(rec.valid), 32'd1);
        chk("baseline_data", 32'(rec.data), 32'h00001);
        while (ts_m != 4'd5) tick(12'h001, 1'b1, 1'b1, 1'b0);
        tick(12'h002, 1'b1, 1'b1, 1'b0);
        chk("change_ts5", 32'(rec.data), 32'({2'b01, 4'd5, 12'h002}));
        tick(12'h002, 1'b1, 1'b1, 1'b0);
        chk("no_repeat", 32'(rec.valid), 32'd0);

        // Wrap record, then change coinciding with wrap
        while (ts_m != 4'hF) tick(12'h002, 1'b1, 1'b1, 1'b0);
        tick(12'h002, 1'b1, 1'b1, 1'b0);
        chk("wrap_rec", 32'(rec.data), 32'({2'b10, 4'hF, 12'h002}));
        while (ts_m != 4'hF) tick(12'h002, 1'b1, 1'b1, 1'b0);
        tick(12'h004, 1'b1, 1'b1, 1'b0);
        chk("change_wrap_rec", 32'(rec.data), 32'({2'b11, 4'hF, 12'h004}));
        tick(12'h004, 1'b0, 1'b1, 1'b0);

        // Overflow: baseline + 10 changes with consumer stalled
        tick(pat(0), 1'b1, 1'b0, 1'b0);
        tick(pat(0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) tick(pat(k), 1'b1, 1'b0, 1'b0);
        chk("ovf_count", 32'(rec.count), 32'd8);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        chk("ovf_drops", 32'(o_drop_count), 32'd3);
        tick(pat(10), 1'b1, 1'b0, 1'b1);
        chk("clear_flag", 32'(o_overflow), 32'd0);
        chk("clear_drops", 32'(o_drop_count), 32'd0);
        tick(pat(11), 1'b1, 1'b1, 1'b0);
        chk("full_pushpop_count", 32'(rec.count), 32'd8);
        chk("full_pushpop_ovf", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 12; i++) tick(pat(11), 1'b0, 1'b1, 1'b0);
        chk("drained", 32'(rec.valid), 32'd0);

        // Drop on the same edge as clear, then saturation
        tick(pat(0), 1'b1, 1'b0, 1'b0);
        tick(pat(0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) tick(pat(k), 1'b1, 1'b0, 1'b0);
        tick(pat(8), 1'b1, 1'b0, 1'b1);
        chk("drop_wins_flag", 32'(o_overflow), 32'd1);
        chk("drop_wins_count", 32'(o_drop_count), 32'd1);
        for (int i = 0; i < 260; i++) tick(pat((i % 2 == 0) ? 9 : 8), 1'b1, 1'b0, 1'b0);
        chk("drops_saturate", 32'(o_drop_count), 32'd255);
        for (int i = 0; i < 10; i++) tick(pat(8), 1'b0, 1'b1, 1'b0);

        // Reset mid-run with five records queued
        tick(pat(0), 1'b1, 1'b0, 1'b0);
        tick(pat(0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) tick(pat(k), 1'b1, 1'b0, 1'b0);
        chk("pre_reset_count", 32'(rec.count), 32'd5);
        #3 i_reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rec.valid), 32'd0);
        chk("async_rst_count", 32'(rec.count), 32'd0);
        q.delete();
        st_m = 2'd0; ts_m = 4'd0; snap_m = 12'd0; ovf_m = 1'b0; drops_m = 8'd0;
        tick(pat(3), 1'b1, 1'b0, 1'b0);
        i_reset = 1'b1;
        tick(pat(3), 1'b1, 1'b1, 1'b0);
        tick(pat(3), 1'b1, 1'b1, 1'b0);
        chk("rearm_baseline", 32'(rec.data), 32'({2'b00, 4'd0, pat(3)}));
        repeat (3) tick(pat(3), 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
